// File: rtl/alu_share_arbiter.sv
// Two-port arbiter sharing one combinational ALU: accept, execute, respond.
// Round-robin tie-break; one response outstanding at a time.
module alu_share_arbiter #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [WIDTH-1:0] req_a0,
  input  logic [WIDTH-1:0] req_b0,
  input  logic [1:0]       req_op0,
  input  logic [WIDTH-1:0] req_a1,
  input  logic [WIDTH-1:0] req_b1,
  input  logic [1:0]       req_op1,
  output logic [1:0]       rsp_valid,
  input  logic [1:0]       rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic [WIDTH-1:0] alu_inA,
  output logic [WIDTH-1:0] alu_inB,
  output logic [1:0]       alu_op,
  input  logic [WIDTH-1:0] alu_ans,
  output logic [CNT_W-1:0] op_count
);

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e           state_q;
  logic             grant_q;
  logic             last_grant_q;
  logic [WIDTH-1:0] alu_a_q;
  logic [WIDTH-1:0] alu_b_q;
  logic [1:0]       alu_op_q;
  logic [WIDTH-1:0] rsp_data_q;
  logic [1:0]       rsp_valid_q;
  logic [CNT_W-1:0] op_count_q;

  logic sel;
  logic sel_valid;

  // On a tie the port that was not served last wins.
  always_comb begin
    sel       = 1'b0;
    sel_valid = |req_valid;
    unique case (req_valid)
      2'b01:   sel = 1'b0;
      2'b10:   sel = 1'b1;
      2'b11:   sel = ~last_grant_q;
      default: sel = 1'b0;
    endcase
  end

  always_comb begin
    req_ready = 2'b00;
    if (state_q == StIdle && sel_valid) begin
      req_ready[sel] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_op_q     <= 2'b00;
      rsp_data_q   <= '0;
      rsp_valid_q  <= 2'b00;
      op_count_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (sel_valid) begin
            alu_a_q  <= sel ? req_a1 : req_a0;
            alu_b_q  <= sel ? req_b1 : req_b0;
            alu_op_q <= sel ? req_op1 : req_op0;
            grant_q  <= sel;
            state_q  <= StExec;
          end
        end
        StExec: begin
          rsp_data_q           <= alu_ans;
          rsp_valid_q[grant_q] <= 1'b1;
          state_q              <= StResp;
        end
        StResp: begin
          if (rsp_ready[grant_q]) begin
            rsp_valid_q  <= 2'b00;
            last_grant_q <= grant_q;
            op_count_q   <= op_count_q + CNT_W'(1);
            state_q      <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign alu_inA   = alu_a_q;
  assign alu_inB   = alu_b_q;
  assign alu_op    = alu_op_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_valid = rsp_valid_q;
  assign op_count  = op_count_q;

endmodule
